chan_drain_ctrl: RTL and testbench

Per-channel readout controller between one channel's circular sample buffer (2048×16 block RAM, 1-cycle read latency) and one requester port of the 16-way output arbiter. Parses block headers in the buffer, waits until a complete block is written, then streams it word-by-word over the arbiter's req/ack handshake without gaps. It is instantiated once per channel, 16 per chip, and drives `req[i]`, `data[16*i+15:16*i]` and consumes `ack[i]`.

---
 rtl/wfd_chan_pkg.sv | 28 ++
 rtl/skid_fifo2.sv | 64 ++++++
 rtl/chan_drain_ctrl.sv | 150 +++++++++++++++
 tb/tb_chan_drain_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wfd_chan_pkg.sv
// Shared constants, FSM state type and header decoding for the per-channel
// waveform buffer readout path.
package wfd_chan_pkg;

   localparam int unsigned AW           = 11;
   localparam int unsigned DW           = 16;
   localparam int unsigned HDR_FLAG_BIT = 15;
   localparam int unsigned LEN_MSB      = 10;

   typedef enum logic [2:0] {
      IDLE,
      RDH,
      CHK,
      WAIT,
      STREAM
   } state_t;

   // Block length from a header word; a zero length field still covers the header itself.
   function automatic logic [AW-1:0] hdr_len(input logic [DW-1:0] w);
      logic [AW-1:0] n;
      n = w[LEN_MSB:0];
      if (n == '0) begin
         n[0] = 1'b1;
      end
      return n;
   endfunction

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry register FIFO, first-word-fall-through: head_o is the oldest entry
// whenever count_o is non-zero. Used as the read prefetch buffer while streaming.
module skid_fifo2 #(
   parameter int unsigned W = 17
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] din_i,
   output logic [W-1:0] head_o,
   output logic [1:0]   count_o
);

   logic [W-1:0] e0_q, e0_d;
   logic [W-1:0] e1_q, e1_d;
   logic [1:0]   cnt_q, cnt_d;
   logic         pop_ok;
   logic         push_ok;

   always_comb begin
      e0_d    = e0_q;
      e1_d    = e1_q;
      cnt_d   = cnt_q;
      pop_ok  = pop_i && (cnt_q != 2'd0);
      push_ok = push_i && ((cnt_q != 2'd2) || pop_ok);
      if (pop_ok) begin
         e0_d  = e1_q;
         cnt_d = cnt_q - 2'd1;
      end
      // Write lands in the first free slot after any same-cycle pop has shifted.
      if (push_ok) begin
         if (cnt_d == 2'd0) begin
            e0_d = din_i;
         end else begin
            e1_d = din_i;
         end
         cnt_d = cnt_d + 2'd1;
      end
      if (clr_i) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e0_q  <= '0;
         e1_q  <= '0;
         cnt_q <= '0;
      end else begin
         e0_q  <= e0_d;
         e1_q  <= e1_d;
         cnt_q <= cnt_d;
      end
   end

   assign head_o  = e0_q;
   assign count_o = cnt_q;

   no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push_i && !clr_i && (cnt_q == 2'd2) && !pop_i));

endmodule

// File: rtl/chan_drain_ctrl.sv
// Per-channel readout: parses block headers in the circular sample buffer, waits
// for a complete block, then streams it gap-free over the arbiter req/ack port.
module chan_drain_ctrl #(
   parameter int unsigned AW = wfd_chan_pkg::AW,
   parameter int unsigned DW = wfd_chan_pkg::DW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] waddr,
   output logic [AW-1:0] raddr,
   input  logic [DW-1:0] rdata,
   input  logic          flush,
   output logic [DW-1:0] dout,
   output logic          last,
   output logic          req,
   input  logic          ack,
   output logic [AW-1:0] rptr,
   output logic          err,
   output logic          busy
);

   import wfd_chan_pkg::*;

   localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

   state_t        state_q;
   logic [AW-1:0] rptr_q;
   logic [AW-1:0] raddr_q;
   logic [AW-1:0] rem_q;
   logic [AW-1:0] len_q;
   logic [AW-1:0] iss_q;
   logic          err_q;
   logic          busy_q;
   logic          infl_q;
   logic          infl_last_q;

   logic [AW-1:0] avail_d;
   logic [DW:0]   skid_head;
   logic [1:0]    skid_cnt;
   logic [1:0]    occ_d;
   logic          req_d;
   logic          pop_d;
   logic          issue_d;
   logic          issue_last_d;

   assign avail_d      = waddr - rptr_q;
   assign req_d        = (skid_cnt != 2'd0);
   assign pop_d        = req_d && ack && !flush;
   // Occupancy net of this cycle's pop keeps one read issued per cycle under
   // continuous ack while never exceeding the two skid slots.
   assign occ_d        = skid_cnt + {1'b0, infl_q} - {1'b0, pop_d};
   assign issue_d      = (state_q == STREAM) && !flush && (iss_q < len_q) && (occ_d < 2'd2);
   assign issue_last_d = (iss_q == (len_q - ONE));

   skid_fifo2 #(
      .W(DW + 1)
   ) u_skid (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (flush),
      .push_i (infl_q),
      .pop_i  (pop_d),
      .din_i  ({infl_last_q, rdata}),
      .head_o (skid_head),
      .count_o(skid_cnt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rptr_q      <= '0;
         raddr_q     <= '0;
         rem_q       <= '0;
         len_q       <= '0;
         iss_q       <= '0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
         infl_q      <= 1'b0;
         infl_last_q <= 1'b0;
      end else begin
         infl_q      <= issue_d;
         infl_last_q <= issue_d && issue_last_d;
         if (flush) begin
            state_q <= IDLE;
            rptr_q  <= waddr;
            rem_q   <= '0;
            busy_q  <= 1'b0;
         end else begin
            unique case (state_q)
               IDLE: begin
                  if (avail_d != '0) begin
                     state_q <= RDH;
                     raddr_q <= rptr_q;
                     busy_q  <= 1'b1;
                  end
               end
               RDH: begin
                  state_q <= CHK;
               end
               CHK: begin
                  if (!rdata[HDR_FLAG_BIT]) begin
                     err_q   <= 1'b1;
                     rptr_q  <= rptr_q + ONE;
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     rem_q   <= hdr_len(rdata);
                     len_q   <= hdr_len(rdata);
                     state_q <= WAIT;
                  end
               end
               WAIT: begin
                  if (avail_d >= len_q) begin
                     state_q <= STREAM;
                     raddr_q <= rptr_q;
                     iss_q   <= '0;
                  end
               end
               STREAM: begin
                  if (issue_d) begin
                     raddr_q <= raddr_q + ONE;
                     iss_q   <= iss_q + ONE;
                  end
                  if (pop_d) begin
                     rptr_q <= rptr_q + ONE;
                     rem_q  <= rem_q - ONE;
                     if (rem_q == ONE) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                     end
                  end
               end
               default: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign raddr = raddr_q;
   assign rptr  = rptr_q;
   assign err   = err_q;
   assign busy  = busy_q;
   assign req   = req_d;
   assign dout  = skid_head[DW-1:0];
   assign last  = skid_head[DW] && req_d;

endmodule

// File: tb/tb_chan_drain_ctrl.sv
// Bench for chan_drain_ctrl: buffer RAM model, block-level reference parser and
// per-cycle compare, directed scenarios plus a randomized writer/acker/flush run.
module tb_chan_drain_ctrl;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [10:0] waddr;
   logic [10:0] raddr;
   logic [15:0] rdata;
   logic        flush;
   logic [15:0] dout;
   logic        last;
   logic        req;
   logic        ack;
   logic [10:0] rptr;
   logic        err;
   logic        busy;

   logic [15:0] mem [0:2047];
   int          vectors     = 0;
   int          miscompares = 0;

   // Reference model state: address of the next word the arbiter must see,
   // position inside the current block, its length and the expected err flag.
   logic [10:0] mrptr;
   int          mpos;
   int          mlen;
   logic        merr;
   logic        p_req, p_ack, p_flush, p_last;
   logic [15:0] p_dout;

   chan_drain_ctrl #(
      .AW(11),
      .DW(16)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .waddr(waddr),
      .raddr(raddr),
      .rdata(rdata),
      .flush(flush),
      .dout (dout),
      .last (last),
      .req  (req),
      .ack  (ack),
      .rptr (rptr),
      .err  (err),
      .busy (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rdata <= mem[raddr];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic wait_req(input int lim);
      int c;
      c = 0;
      while (!req && c < lim) begin
         @(negedge clk);
         c++;
      end
      chk("req_timeout", req, 1);
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         mrptr   = '0;
         mpos    = 0;
         mlen    = 1;
         merr    = 1'b0;
         p_req   = 1'b0;
         p_ack   = 1'b0;
         p_flush = 1'b0;
         p_last  = 1'b0;
         p_dout  = '0;
      end else begin
         if (p_req && !p_ack && !p_flush) begin
            chk("hold_req", req, 1);
            chk("hold_dout", dout, p_dout);
         end
         if (p_req && p_ack && p_last && !p_flush) begin
            chk("req_fall", req, 0);
         end
         if (req) begin
            if (mpos == 0) begin
               for (int k = 0; k < 2048 && !mem[mrptr][15]; k++) begin
                  mrptr++;
                  merr = 1'b1;
               end
               mlen = int'(mem[mrptr][10:0]);
               if (mlen == 0) mlen = 1;
            end
            chk("dout", dout, mem[mrptr]);
            chk("last", last, (mpos == mlen - 1));
            chk("rptr", rptr, mrptr);
            chk("err", err, merr);
         end else if (mpos != 0) begin
            chk("rptr_mid", rptr, mrptr);
         end
         if (flush) begin
            mrptr = waddr;
            mpos  = 0;
         end else if (req && ack) begin
            mrptr++;
            mpos++;
            if (mpos == mlen) mpos = 0;
         end
         p_req   = req;
         p_ack   = ack;
         p_flush = flush;
         p_last  = last;
         p_dout  = dout;
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: time %0t exceeded limit", $time);
      $fatal(1);
   end

   initial begin
      logic [15:0]  wexp [0:4];
      logic [15:0]  q [$];
      logic [10:0]  used;
      logic [10:0]  base;
      logic [15:0]  hdr;
      int           n;
      int           k;

      waddr = '0;
      flush = 1'b0;
      ack   = 1'b0;
      for (int i = 0; i < 2048; i++) mem[i] = '0;

      // reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_raddr", raddr, 0);
      chk("rst_dout", dout, 0);
      chk("rst_last", last, 0);
      chk("rst_req", req, 0);
      chk("rst_rptr", rptr, 0);
      chk("rst_err", err, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;

      // empty buffer stays idle
      repeat (20) begin
         @(negedge clk);
         chk("empty_req", req, 0);
         chk("empty_busy", busy, 0);
         chk("empty_raddr", raddr, 0);
      end

      // five-word block under continuous ack
      @(posedge clk);
      #1;
      mem[0]  = 16'h8005;
      wexp[0] = 16'h8005;
      for (int i = 1; i < 5; i++) begin
         mem[i]  = 16'($urandom);
         wexp[i] = mem[i];
      end
      waddr = 11'd5;
      ack   = 1'b1;
      wait_req(50);
      n = 0;
      while (req && n < 20) begin
         if (n < 5) begin
            chk("t2_word", dout, wexp[n]);
            chk("t2_last", last, (n == 4));
         end
         n++;
         @(negedge clk);
      end
      chk("t2_len", n, 5);
      chk("t2_rptr", rptr, 5);

      // same block written one word per ten cycles
      @(posedge clk);
      #1;
      mem[5] = 16'h8005;
      for (int i = 6; i < 10; i++) mem[i] = 16'($urandom);
      for (int i = 1; i <= 5; i++) begin
         waddr = 11'(5 + i);
         if (i < 5) begin
            repeat (10) begin
               @(negedge clk);
               chk("t3_noreq", req, 0);
            end
            chk("t3_busy", busy, 1);
            @(posedge clk);
            #1;
         end
      end
      k = 0;
      while (k < 20) begin
         @(posedge clk);
         k++;
         @(negedge clk);
         if (req) break;
      end
      chk("t3_latency", k, 3);
      n = 0;
      while (req && n < 20) begin
         n++;
         @(negedge clk);
      end
      chk("t3_len", n, 5);
      chk("t3_rptr", rptr, 10);

      // six-word block wrapping past the top of the buffer
      @(posedge clk);
      #1;
      waddr = 11'd2045;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush     = 1'b0;
      mem[2045] = 16'h8006;
      mem[2046] = 16'($urandom);
      mem[2047] = 16'($urandom);
      for (int i = 0; i < 3; i++) mem[i] = 16'($urandom);
      waddr = 11'd3;
      wait_req(40);
      chk("t4_first", dout, 16'h8006);
      n = 0;
      while (req && n < 20) begin
         n++;
         @(negedge clk);
      end
      chk("t4_len", n, 6);
      chk("t4_rptr", rptr, 3);

      // malformed header followed by a valid two-word block
      @(posedge clk);
      #1;
      mem[3] = 16'h1234;
      mem[4] = 16'h8002;
      mem[5] = 16'($urandom);
      waddr  = 11'd6;
      wait_req(40);
      chk("t5_err", err, 1);
      chk("t5_hdr", dout, 16'h8002);
      chk("t5_rptr_hdr", rptr, 4);
      n = 0;
      while (req && n < 20) begin
         n++;
         @(negedge clk);
      end
      chk("t5_len", n, 2);
      chk("t5_rptr", rptr, 6);

      // flush together with ack in the middle of an eight-word block
      @(posedge clk);
      #1;
      mem[6] = 16'h8008;
      for (int i = 7; i < 14; i++) mem[i] = 16'($urandom);
      waddr = 11'd14;
      wait_req(40);
      @(posedge clk);
      @(posedge clk);
      #1;
      flush = 1'b1;
      @(negedge clk);
      chk("t6_pre_rptr", rptr, 8);
      chk("t6_pre_req", req, 1);
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      chk("t6_req", req, 0);
      chk("t6_rptr", rptr, 14);
      chk("t6_busy", busy, 0);
      repeat (5) begin
         @(negedge clk);
         chk("t6_idle_req", req, 0);
      end

      // randomized writer, acker and occasional flush
      for (int cyc = 0; cyc < 12000 && (cyc < 8000 || q.size() != 0); cyc++) begin
         @(posedge clk);
         #1;
         ack   = ($urandom_range(0, 3) != 0);
         flush = 1'b0;
         if (cyc < 8000 && q.size() == 0) begin
            if ($urandom_range(0, 7) == 0) begin
               q.push_back(16'($urandom_range(0, 16'h7fff)));
            end else begin
               n   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(10, 40))
                                                 : int'($urandom_range(0, 9));
               hdr = {1'b1, 4'($urandom_range(0, 15)), 11'(n)};
               q.push_back(hdr);
               for (int j = 1; j < ((n == 0) ? 1 : n); j++) q.push_back(16'($urandom));
            end
         end
         used = waddr - rptr;
         if (cyc < 8000 && $urandom_range(0, 499) == 0) begin
            flush = 1'b1;
            q.delete();
         end else if (q.size() != 0 && $urandom_range(0, 2) != 0 && used < 11'd2047) begin
            mem[waddr] = q.pop_front();
            waddr      = waddr + 11'd1;
         end
      end
      @(posedge clk);
      #1;
      ack   = 1'b1;
      flush = 1'b0;
      k = 0;
      @(negedge clk);
      while (!(rptr == waddr && !busy && !req) && k < 2000) begin
         @(negedge clk);
         k++;
      end
      chk("drain_rptr", rptr, waddr);
      chk("drain_busy", busy, 0);
      chk("model_pos", mpos, 0);
      for (int i = 0; i < 2048 && mrptr != waddr && !mem[mrptr][15]; i++) mrptr++;
      chk("model_rptr", rptr, mrptr);

      // asynchronous reset in the middle of a block
      @(posedge clk);
      #1;
      ack  = 1'b0;
      base = waddr;
      mem[base] = 16'h8010;
      for (int j = 1; j < 16; j++) mem[base + 11'(j)] = 16'($urandom);
      waddr = base + 11'd16;
      wait_req(40);
      chk("t8_busy_pre", busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t8_raddr", raddr, 0);
      chk("t8_dout", dout, 0);
      chk("t8_last", last, 0);
      chk("t8_req", req, 0);
      chk("t8_rptr", rptr, 0);
      chk("t8_err", err, 0);
      chk("t8_busy", busy, 0);
      @(posedge clk);
      #1;
      waddr = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (10) begin
         @(negedge clk);
         chk("t8_post_req", req, 0);
         chk("t8_post_busy", busy, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
